// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner for a common-anode seven-segment display with blanking gaps.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shows).
module seven_seg_scanner #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  DividedClock,
  input  logic                  Enable,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic [DIGITS-1:0]     DecimalPoints,
  output logic [DIGITS-1:0]     Anode,
  output logic [6:0]            Cathode,
  output logic                  DP,
  output logic                  FrameStart
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(BLANK_CYCLES + 1);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic [2:0]            sync;
  logic                  tick;
  logic [1:0]            state, state_n;
  logic [IW-1:0]         index, index_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [4*DIGITS-1:0]   sval, sval_n;
  logic [DIGITS-1:0]     sdp, sdp_n;
  logic                  fs_n;
  logic [DIGITS-1:0]     anode_n;
  logic [6:0]            cath_n;
  logic                  dp_n;
  logic [3:0]            nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is a leading zero when it and every higher digit carry no nibble and no DP.
  function automatic logic leading_zero(input logic [4*DIGITS-1:0] v,
                                        input logic [DIGITS-1:0] d,
                                        input logic [IW-1:0] i);
    logic z;
    z = (i != '0);
    for (int unsigned k = 0; k < DIGITS; k++)
      if (k >= 32'(i) && (v[4*k +: 4] != 4'h0 || d[k])) z = 1'b0;
    return z;
  endfunction
`endif

  // Two-flop synchroniser plus registered rising-edge detect.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync <= '0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[1:0], DividedClock};
      tick <= sync[1] & ~sync[2];
    end
  end

  always_comb begin
    state_n = state;
    index_n = index;
    cnt_n   = cnt;
    sval_n  = sval;
    sdp_n   = sdp;
    fs_n    = 1'b0;
    if (!Enable) begin
      state_n = ST_OFF;
      index_n = LAST_IDX;
    end else begin
      case (state)
        ST_OFF, ST_DRIVE: begin
          if (tick) begin
            if (index == LAST_IDX) begin
              index_n = '0;
              sval_n  = Value;
              sdp_n   = DecimalPoints;
              fs_n    = 1'b1;
            end else begin
              index_n = index + 1'b1;
            end
            state_n = ST_BLANK;
            cnt_n   = CW'(BLANK_CYCLES - 1);
          end
        end
        ST_BLANK: begin
          if (cnt == '0) state_n = ST_DRIVE;
          else           cnt_n   = cnt - 1'b1;
        end
        default: state_n = ST_OFF;
      endcase
    end
  end

  // Pad values are decoded from next-state so they register in step with the FSM.
  always_comb begin
    anode_n = '1;
    cath_n  = 7'h7F;
    dp_n    = 1'b1;
    nib     = sval_n[4*index_n +: 4];
    if (state_n == ST_DRIVE) begin
      anode_n[index_n] = 1'b0;
      cath_n           = seg_decode(nib);
      dp_n             = ~sdp_n[index_n];
`ifdef LEADING_ZERO_BLANK_EN
      if (leading_zero(sval_n, sdp_n, index_n)) begin
        cath_n = 7'h7F;
        dp_n   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_OFF;
      index      <= LAST_IDX;
      cnt        <= '0;
      sval       <= '0;
      sdp        <= '0;
      Anode      <= '1;
      Cathode    <= 7'h7F;
      DP         <= 1'b1;
      FrameStart <= 1'b0;
    end else begin
      state      <= state_n;
      index      <= index_n;
      cnt        <= cnt_n;
      sval       <= sval_n;
      sdp        <= sdp_n;
      Anode      <= anode_n;
      Cathode    <= cath_n;
      DP         <= dp_n;
      FrameStart <= fs_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: expected digits are queued per tick and compared at each DRIVE start.
module tb_seven_seg_scanner;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BLANK  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        divclk;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dps;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        fs;

  seven_seg_scanner #(.DIGITS(DIGITS), .BLANK_CYCLES(BLANK)) dut (
    .Clock(clk), .Reset(rst_n), .DividedClock(divclk), .Enable(en),
    .Value(value), .DecimalPoints(dps), .Anode(anode), .Cathode(cathode),
    .DP(dp), .FrameStart(fs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] anode;
    logic [6:0] cathode;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t        q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned drive_cnt = 0;
  int unsigned fs_cnt = 0;
  int unsigned dark = 0;
  logic        seen_fs = 1'b0;
  logic        prev_driven = 1'b0;

  logic [1:0]  m_idx = 2'd3;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  task automatic push_expect();
    exp_t e;
    logic [3:0] nib;
    if (m_idx == 2'd3) begin
      m_idx = 2'd0;
      m_val = value;
      m_dp  = dps;
      e.fs  = 1'b1;
    end else begin
      m_idx = m_idx + 2'd1;
      e.fs  = 1'b0;
    end
    nib       = m_val[4*m_idx +: 4];
    e.anode   = ~(4'b0001 << m_idx);
    e.cathode = seg_of(nib);
    e.dp      = ~m_dp[m_idx];
`ifdef LEADING_ZERO_BLANK_EN
    if (m_idx != 2'd0 && (m_val >> (4*m_idx)) == 16'h0 && (m_dp >> m_idx) == 4'h0) begin
      e.cathode = 7'h7F;
      e.dp      = 1'b1;
    end
`endif
    q.push_back(e);
  endtask

  task automatic wait_drive(input int unsigned start);
    int unsigned n;
    n = 0;
    while (drive_cnt == start && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (drive_cnt == start) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_dark();
    int unsigned n;
    n = 0;
    while (anode != 4'hF && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (anode != 4'hF) check("dark_timeout", 32'(anode), 32'hF);
  endtask

  task automatic do_tick();
    int unsigned start;
    start = drive_cnt;
    push_expect();
    @(negedge clk) divclk = 1'b1;
    wait_drive(start);
    divclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every dark->driven transition is one scanned digit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen_fs     = 1'b0;
      prev_driven = 1'b0;
      dark        = 0;
    end else begin
      if (fs) begin
        seen_fs = 1'b1;
        fs_cnt++;
      end
      if (anode == 4'hF) begin
        if (fs || prev_driven) dark = 1;
        else dark++;
        prev_driven = 1'b0;
      end else begin
        if (!prev_driven) begin
          drive_cnt++;
          if (q.size() == 0) begin
            check("unexpected_drive", 32'(anode), 32'hF);
          end else begin
            e = q.pop_front();
            check("anode", 32'(anode), 32'(e.anode));
            check("cathode", 32'(cathode), 32'(e.cathode));
            check("dp", 32'(dp), 32'(e.dp));
            check("framestart", 32'(seen_fs), 32'(e.fs));
            check("blank_len", dark, BLANK);
          end
          seen_fs = 1'b0;
        end
        prev_driven = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned start;
    int unsigned fs0;
    rst_n = 1'b0; divclk = 1'b0; en = 1'b0; value = '0; dps = '0;
    repeat (3) @(negedge clk);
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_cathode", 32'(cathode), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_fs", 32'(fs), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic scan of 0x1234, then wrap.
    en = 1'b1; value = 16'h1234; dps = 4'b0000;
    repeat (5) do_tick();

    // Mid-frame value change only shows after the next frame start.
    do_tick(); do_tick();
    value = 16'hABCD;
    repeat (5) do_tick();

    // Decimal points and mixed nibbles.
    value = 16'hF00E; dps = 4'b0100;
    repeat (5) do_tick();

    // Second DividedClock edge landing inside BLANK must be ignored.
    start = drive_cnt;
    push_expect();
    @(negedge clk) divclk = 1'b1;
    wait_dark();
    @(negedge clk) divclk = 1'b0;
    @(negedge clk) divclk = 1'b1;
    wait_drive(start);
    repeat (30) @(negedge clk);
    check("single_advance", drive_cnt - start, 32'd1);
    divclk = 1'b0;
    repeat (4) @(negedge clk);

    // Enable dropped during BLANK restarts at digit 0.
    @(negedge clk) divclk = 1'b1;
    wait_dark();
    @(negedge clk) en = 1'b0;
    @(negedge clk);
    check("dis_anode", 32'(anode), 32'hF);
    check("dis_cathode", 32'(cathode), 32'h7F);
    divclk = 1'b0;
    m_idx = 2'd3;
    repeat (20) @(negedge clk);
    check("off_anode", 32'(anode), 32'hF);
    en = 1'b1;
    do_tick(); do_tick();

    // Asynchronous reset mid-DRIVE.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_anode", 32'(anode), 32'hF);
    check("arst_cathode", 32'(cathode), 32'h7F);
    check("arst_dp", 32'(dp), 32'd1);
    check("arst_fs", 32'(fs), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_idx = 2'd3; m_val = '0; m_dp = '0;
    fs0 = fs_cnt;
    repeat (20) @(negedge clk);
    check("no_fs_after_rst", fs_cnt - fs0, 32'd0);

    // Leading-zero case 0x0050.
    value = 16'h0050; dps = 4'b0000;
    repeat (4) do_tick();

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
